// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode definitions: opcode constants, pipeline register
// layouts and the decode-stage action encoding.
package legv8_pkg;

  localparam int XLEN = 64;

  localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
  localparam logic [7:0]  OP_CBZ  = 8'b1011_0100;
  localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
  localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
  localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
  localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic            valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } ifid_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic            memread;
    logic [XLEN-1:0] pc;
  } idex_t;

  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_STALL   = 2'd1,
    ACT_FLUSH   = 2'd2,
    ACT_FREEZE  = 2'd3
  } act_e;

  localparam ifid_t IFID_BUBBLE = '{valid: 1'b0, instr: 32'd0, pc: {XLEN{1'b0}}};
  localparam idex_t IDEX_BUBBLE = '{valid: 1'b0, imm: {XLEN{1'b0}}, rd: 5'd0,
                                    memread: 1'b0, pc: {XLEN{1'b0}}};

  function automatic logic is_ldst(input logic [31:0] instr);
    return (instr[31:21] == OP_LDUR) || (instr[31:21] == OP_STUR);
  endfunction

endpackage

// File: rtl/signext.sv
// Immediate generator: D-format (LDUR/STUR) and CB-format (CBZ) sign extension.
module signext
  import legv8_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [31:0]  instr,
  output logic [N-1:0] imm
);

  logic unused_bits_s;
  assign unused_bits_s = ^instr[11:0];

  // opcode-selected sign extension; unknown opcodes give zero
  always_comb begin
    imm = {N{1'b0}};
    if (is_ldst(instr)) begin
      imm = {{(N-9){instr[20]}}, instr[20:12]};
    end else if (instr[31:24] == OP_CBZ) begin
      imm = {{(N-19){instr[23]}}, instr[23:5]};
    end else begin
      imm = {N{1'b0}};
    end
  end

endmodule

// File: rtl/decode_ctrl.sv
// Decode-stage controller: owns IF/ID and the ID/EX immediate/control fields,
// resolves freeze > flush > load-use stall > advance, and counts events.
module decode_ctrl
  import legv8_pkg::*;
#(
  parameter int N     = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic [N-1:0]     if_pc,
  input  logic             mem_busy,
  input  logic             mem_branch_taken,
  output logic             pc_write,
  output logic             ex_flush,
  output logic             ifid_valid,
  output logic [31:0]      ifid_instr,
  output logic [N-1:0]     ifid_pc,
  output logic             idex_valid,
  output logic [N-1:0]     idex_imm,
  output logic [4:0]       idex_rd,
  output logic             idex_memread,
  output logic [N-1:0]     idex_pc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ifid_t            ifid_r, ifid_nxt_s;
  idex_t            idex_r, idex_nxt_s;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
  logic [N-1:0]     imm_s;
  logic [10:0]      op11_s;
  logic             is_ldur_s, is_stur_s, is_cbz_s, is_rfmt_s;
  logic             use_rs1_s, use_rs2_s;
  logic [4:0]       rs1_s, rs2_s;
  logic             hz_s;
  act_e             act_s;

  signext #(.N(N)) u_signext (
    .instr (ifid_r.instr),
    .imm   (imm_s)
  );

  // source-register usage of the instruction in IF/ID and load-use detection
  always_comb begin
    op11_s    = ifid_r.instr[31:21];
    is_ldur_s = (op11_s == OP_LDUR);
    is_stur_s = (op11_s == OP_STUR);
    is_cbz_s  = (ifid_r.instr[31:24] == OP_CBZ);
    is_rfmt_s = (op11_s == OP_ADD) || (op11_s == OP_SUB) ||
                (op11_s == OP_AND) || (op11_s == OP_ORR);
    rs1_s     = ifid_r.instr[9:5];
    use_rs1_s = !is_cbz_s;
    rs2_s     = 5'd0;
    use_rs2_s = 1'b0;
    if (is_rfmt_s) begin
      rs2_s     = ifid_r.instr[20:16];
      use_rs2_s = 1'b1;
    end else if (is_stur_s || is_cbz_s) begin
      rs2_s     = ifid_r.instr[4:0];
      use_rs2_s = 1'b1;
    end else begin
      rs2_s     = 5'd0;
      use_rs2_s = 1'b0;
    end
    hz_s = idex_r.valid && idex_r.memread && ifid_r.valid && (idex_r.rd != XZR) &&
           ((use_rs1_s && (idex_r.rd == rs1_s)) || (use_rs2_s && (idex_r.rd == rs2_s)));
  end

  // per-cycle action by priority; a pending branch waits out a memory freeze
  always_comb begin
    if (mem_busy) begin
      act_s = ACT_FREEZE;
    end else if (mem_branch_taken) begin
      act_s = ACT_FLUSH;
    end else if (hz_s) begin
      act_s = ACT_STALL;
    end else begin
      act_s = ACT_ADVANCE;
    end
  end

  // next contents of IF/ID and ID/EX for the chosen action
  always_comb begin
    ifid_nxt_s = ifid_r;
    idex_nxt_s = idex_r;
    case (act_s)
      ACT_FREEZE: begin
        ifid_nxt_s = ifid_r;
        idex_nxt_s = idex_r;
      end
      ACT_FLUSH: begin
        ifid_nxt_s = IFID_BUBBLE;
        idex_nxt_s = IDEX_BUBBLE;
      end
      ACT_STALL: begin
        ifid_nxt_s = ifid_r;
        idex_nxt_s = IDEX_BUBBLE;
      end
      ACT_ADVANCE: begin
        ifid_nxt_s.valid   = if_valid;
        ifid_nxt_s.instr   = if_instr;
        ifid_nxt_s.pc      = XLEN'(if_pc);
        idex_nxt_s.valid   = ifid_r.valid;
        idex_nxt_s.imm     = XLEN'(imm_s);
        idex_nxt_s.rd      = ifid_r.instr[4:0];
        idex_nxt_s.memread = ifid_r.valid && is_ldur_s;
        idex_nxt_s.pc      = ifid_r.pc;
      end
      default: begin
        ifid_nxt_s = ifid_r;
        idex_nxt_s = idex_r;
      end
    endcase
  end

  // pipeline registers and saturating event counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifid_r      <= IFID_BUBBLE;
      idex_r      <= IDEX_BUBBLE;
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      ifid_r <= ifid_nxt_s;
      idex_r <= idex_nxt_s;
      if ((act_s == ACT_STALL) && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if ((act_s == ACT_FLUSH) && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign pc_write     = reset && ((act_s == ACT_ADVANCE) || (act_s == ACT_FLUSH));
  assign ex_flush     = reset && (act_s == ACT_FLUSH);
  assign ifid_valid   = ifid_r.valid;
  assign ifid_instr   = ifid_r.instr;
  assign ifid_pc      = ifid_r.pc[N-1:0];
  assign idex_valid   = idex_r.valid;
  assign idex_imm     = idex_r.imm[N-1:0];
  assign idex_rd      = idex_r.rd;
  assign idex_memread = idex_r.memread;
  assign idex_pc      = idex_r.pc[N-1:0];
  assign stall_cnt    = stall_cnt_r;
  assign flush_cnt    = flush_cnt_r;

endmodule

// File: tb/tb_decode_ctrl.sv
// Directed bench for decode_ctrl: immediates, load-use stall, flush priority,
// memory freeze, counter saturation (CNT_W=4) and asynchronous reset.
module tb_decode_ctrl;

  localparam int N     = 64;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             if_valid;
  logic [31:0]      if_instr;
  logic [N-1:0]     if_pc;
  logic             mem_busy;
  logic             mem_branch_taken;
  logic             pc_write;
  logic             ex_flush;
  logic             ifid_valid;
  logic [31:0]      ifid_instr;
  logic [N-1:0]     ifid_pc;
  logic             idex_valid;
  logic [N-1:0]     idex_imm;
  logic [4:0]       idex_rd;
  logic             idex_memread;
  logic [N-1:0]     idex_pc;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int n_cmp = 0;
  int n_mis = 0;
  int exp_stall;

  decode_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .if_valid         (if_valid),
    .if_instr         (if_instr),
    .if_pc            (if_pc),
    .mem_busy         (mem_busy),
    .mem_branch_taken (mem_branch_taken),
    .pc_write         (pc_write),
    .ex_flush         (ex_flush),
    .ifid_valid       (ifid_valid),
    .ifid_instr       (ifid_instr),
    .ifid_pc          (ifid_pc),
    .idex_valid       (idex_valid),
    .idex_imm         (idex_imm),
    .idex_rd          (idex_rd),
    .idex_memread     (idex_memread),
    .idex_pc          (idex_pc),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc);
    if_valid = v;
    if_instr = ins;
    if_pc    = pc;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [63:0] pc);
    drive(1'b1, ins, pc);
    tick();
    drive(1'b0, 32'd0, 64'd0);
    tick();
  endtask

  function automatic logic [31:0] ldur(input logic [4:0] rt, input logic [4:0] rn,
                                       input logic [8:0] imm9);
    return {11'b111_1100_0010, imm9, 2'b00, rn, rt};
  endfunction

  function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rn,
                                      input logic [4:0] rm);
    return {11'b100_0101_1000, rm, 6'd0, rn, rd};
  endfunction

  function automatic logic [31:0] orr(input logic [4:0] rd, input logic [4:0] rn,
                                      input logic [4:0] rm);
    return {11'b101_0101_0000, rm, 6'd0, rn, rd};
  endfunction

  function automatic logic [31:0] cbz(input logic [4:0] rt, input logic [18:0] imm19);
    return {8'b1011_0100, imm19, rt};
  endfunction

  initial begin
    reset = 1'b0;
    mem_busy = 1'b0;
    mem_branch_taken = 1'b0;
    drive(1'b0, 32'd0, 64'd0);
    #2;
    check("rst_ifid_valid", 64'(ifid_valid), 64'd0);
    check("rst_idex_valid", 64'(idex_valid), 64'd0);
    check("rst_pc_write", 64'(pc_write), 64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    tick();
    tick();
    reset = 1'b1;

    // immediates
    issue({11'b111_1100_0010, 9'h1FF, 12'h000}, 64'h40);
    check("ldur_neg_imm", idex_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("ldur_memread", 64'(idex_memread), 64'd1);
    check("ldur_valid", 64'(idex_valid), 64'd1);
    check("ldur_pc", idex_pc, 64'h40);
    issue({11'b111_1100_0010, 9'h0FF, 12'h000}, 64'h44);
    check("ldur_pos_imm", idex_imm, 64'hFF);
    issue({8'b1011_0100, 19'h3FFFF, 5'd0}, 64'h48);
    check("cbz_pos_imm", idex_imm, 64'h3FFFF);
    check("cbz_memread", 64'(idex_memread), 64'd0);
    issue({8'b1011_0100, 19'h7FFFF, 5'd0}, 64'h4C);
    check("cbz_neg_imm", idex_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(32'h1, 64'h50);
    check("other_imm", idex_imm, 64'd0);
    check("other_rd", 64'(idex_rd), 64'd1);

    // load-use: LDUR X2,[X1] ; ADD X3,X2,X4
    drive(1'b1, ldur(5'd2, 5'd1, 9'd0), 64'h100);
    tick();
    drive(1'b1, add(5'd3, 5'd2, 5'd4), 64'h104);
    tick();
    drive(1'b1, orr(5'd5, 5'd6, 5'd7), 64'h108);
    #1;
    check("lu_pc_write", 64'(pc_write), 64'd0);
    check("lu_ex_flush", 64'(ex_flush), 64'd0);
    tick();
    check("lu_ifid_hold", 64'(ifid_instr), 64'(add(5'd3, 5'd2, 5'd4)));
    check("lu_ifid_pc", ifid_pc, 64'h104);
    check("lu_bubble", 64'(idex_valid), 64'd0);
    check("lu_stall_cnt", 64'(stall_cnt), 64'd1);
    check("lu_resume_pcw", 64'(pc_write), 64'd1);
    tick();
    check("lu_add_valid", 64'(idex_valid), 64'd1);
    check("lu_add_rd", 64'(idex_rd), 64'd3);
    check("lu_add_pc", idex_pc, 64'h104);
    check("lu_add_memread", 64'(idex_memread), 64'd0);
    check("lu_ifid_next", 64'(ifid_instr), 64'(orr(5'd5, 5'd6, 5'd7)));
    drive(1'b0, 32'd0, 64'd0);
    tick();
    tick();

    // LDUR to XZR never creates a hazard
    drive(1'b1, ldur(5'd31, 5'd1, 9'd0), 64'h120);
    tick();
    drive(1'b1, add(5'd3, 5'd31, 5'd4), 64'h124);
    tick();
    drive(1'b0, 32'd0, 64'd0);
    #1;
    check("xzr_pc_write", 64'(pc_write), 64'd1);
    tick();
    check("xzr_add_valid", 64'(idex_valid), 64'd1);
    check("xzr_add_pc", idex_pc, 64'h124);
    check("xzr_stall_cnt", 64'(stall_cnt), 64'd1);
    tick();

    // branch flush wins over a simultaneous load-use hazard
    drive(1'b1, ldur(5'd2, 5'd1, 9'd0), 64'h140);
    tick();
    drive(1'b1, add(5'd3, 5'd2, 5'd4), 64'h144);
    tick();
    drive(1'b0, 32'd0, 64'd0);
    mem_branch_taken = 1'b1;
    #1;
    check("fl_pc_write", 64'(pc_write), 64'd1);
    check("fl_ex_flush", 64'(ex_flush), 64'd1);
    tick();
    mem_branch_taken = 1'b0;
    check("fl_ifid_valid", 64'(ifid_valid), 64'd0);
    check("fl_ifid_instr", 64'(ifid_instr), 64'd0);
    check("fl_idex_valid", 64'(idex_valid), 64'd0);
    check("fl_idex_memread", 64'(idex_memread), 64'd0);
    check("fl_flush_cnt", 64'(flush_cnt), 64'd1);
    check("fl_stall_cnt", 64'(stall_cnt), 64'd1);

    // memory freeze holds everything and defers the branch
    drive(1'b1, ldur(5'd7, 5'd8, 9'h004), 64'h1F0);
    tick();
    drive(1'b1, cbz(5'd9, 19'd5), 64'h200);
    tick();
    drive(1'b1, add(5'd1, 5'd2, 5'd3), 64'h204);
    mem_busy = 1'b1;
    mem_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("fz_pc_write", 64'(pc_write), 64'd0);
      check("fz_ex_flush", 64'(ex_flush), 64'd0);
      tick();
      check("fz_ifid_pc", ifid_pc, 64'h200);
      check("fz_idex_rd", 64'(idex_rd), 64'd7);
      check("fz_idex_imm", idex_imm, 64'd4);
      check("fz_idex_valid", 64'(idex_valid), 64'd1);
      check("fz_flush_cnt", 64'(flush_cnt), 64'd1);
    end
    mem_busy = 1'b0;
    #1;
    check("fz_rel_pc_write", 64'(pc_write), 64'd1);
    check("fz_rel_ex_flush", 64'(ex_flush), 64'd1);
    tick();
    mem_branch_taken = 1'b0;
    drive(1'b0, 32'd0, 64'd0);
    check("fz_rel_flush_cnt", 64'(flush_cnt), 64'd2);
    check("fz_rel_ifid_valid", 64'(ifid_valid), 64'd0);
    check("fz_rel_idex_valid", 64'(idex_valid), 64'd0);

    // 16 more load-use stalls: 17 total saturates a 4-bit counter at 15
    exp_stall = 1;
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, ldur(5'd2, 5'd1, 9'd0), 64'h400);
      tick();
      drive(1'b1, add(5'd3, 5'd2, 5'd4), 64'h404);
      tick();
      drive(1'b0, 32'd0, 64'd0);
      #1;
      check("sat_pc_write", 64'(pc_write), 64'd0);
      tick();
      exp_stall = (exp_stall < 15) ? exp_stall + 1 : 15;
      check("sat_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
      tick();
    end
    check("sat_final", 64'(stall_cnt), 64'd15);

    // asynchronous reset in the middle of a stall
    drive(1'b1, ldur(5'd2, 5'd1, 9'd0), 64'h500);
    tick();
    drive(1'b1, add(5'd3, 5'd2, 5'd4), 64'h504);
    tick();
    check("mid_pc_write", 64'(pc_write), 64'd0);
    reset = 1'b0;
    #1;
    check("ar_pc_write", 64'(pc_write), 64'd0);
    check("ar_ex_flush", 64'(ex_flush), 64'd0);
    check("ar_ifid_valid", 64'(ifid_valid), 64'd0);
    check("ar_ifid_instr", 64'(ifid_instr), 64'd0);
    check("ar_idex_valid", 64'(idex_valid), 64'd0);
    check("ar_idex_imm", idex_imm, 64'd0);
    check("ar_stall_cnt", 64'(stall_cnt), 64'd0);
    check("ar_flush_cnt", 64'(flush_cnt), 64'd0);
    tick();
    reset = 1'b1;
    issue(ldur(5'd5, 5'd6, 9'h003), 64'h300);
    check("post_rst_valid", 64'(idex_valid), 64'd1);
    check("post_rst_memread", 64'(idex_memread), 64'd1);
    check("post_rst_imm", idex_imm, 64'd3);
    check("post_rst_pc", idex_pc, 64'h300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
